// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared state encoding, opcode constants and delay helper for
//               the HD44780-style LCD controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_W15     = 4'd0,
        ST_P3A     = 4'd1,
        ST_W4_1    = 4'd2,
        ST_P3B     = 4'd3,
        ST_W100    = 4'd4,
        ST_P3C     = 4'd5,
        ST_W40A    = 4'd6,
        ST_P2      = 4'd7,
        ST_W40B    = 4'd8,
        ST_CFG_FS  = 4'd9,
        ST_CFG_EM  = 4'd10,
        ST_CFG_DC  = 4'd11,
        ST_CFG_CLR = 4'd12,
        ST_W1_64   = 4'd13,
        ST_DONE    = 4'd14
    } lcd_state_e;

    localparam logic [7:0] c_op_clr   = 8'h01;
    localparam logic [7:0] c_op_entry = 8'h04;
    localparam logic [7:0] c_op_disp  = 8'h08;
    localparam logic [7:0] c_op_fset  = 8'h20;

    // Raw wake-up words already carry RS = RW = 0.
    localparam logic [9:0] c_raw3_4bit = 10'h003;
    localparam logic [9:0] c_raw3_8bit = 10'h030;
    localparam logic [9:0] c_raw2      = 10'h002;

    // Delay in tenths of a microsecond converted to whole clock cycles.
    function automatic longint us_to_cycles(input longint clk_hz, input longint tenth_us);
        return (clk_hz / 10_000) * tenth_us / 1_000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_wait_timer
// Description : Loadable down-counter that holds at zero; expired while zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_wait_timer #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RESET_VALUE;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_ctrl
// Description : Power-on wake-up and configuration sequencer for an
//               HD44780-style LCD, with restart support.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DATA_MODE    = 0,
    parameter int TWO_LINE     = 1,
    parameter int FONT_5X10    = 0,
    parameter int ENTRY_INC    = 1,
    parameter int ENTRY_SHIFT  = 0,
    parameter int CURSOR_ON    = 0,
    parameter int BLINK_ON     = 0,
    parameter int PULSE_CYCLES = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       instr_done,
    output logic       instr_enable,
    output logic [9:0] instruction,
    output logic       e,
    output logic       init_done,
    output logic       busy
);

    localparam int c_t15   = CLK_HZ / 1000 * 15;
    localparam int c_t4_1  = CLK_HZ / 10000 * 41;
    localparam int c_t100  = CLK_HZ / 10000;
    localparam int c_t40   = CLK_HZ / 100000 * 4;
    localparam int c_t1_64 = CLK_HZ / 100000 * 164;
    localparam int c_cnt_w = (c_t15 > 1) ? $clog2(c_t15) : 1;

    localparam logic [9:0] c_raw3 = (DATA_MODE != 0) ? c_raw3_8bit : c_raw3_4bit;

    localparam logic [7:0] c_fs_byte = c_op_fset
        | ((DATA_MODE != 0) ? 8'h10 : 8'h00)
        | ((TWO_LINE  != 0) ? 8'h08 : 8'h00)
        | ((FONT_5X10 != 0) ? 8'h04 : 8'h00);
    localparam logic [7:0] c_em_byte = c_op_entry
        | ((ENTRY_INC   != 0) ? 8'h02 : 8'h00)
        | ((ENTRY_SHIFT != 0) ? 8'h01 : 8'h00);
    // Display-on always sets the D bit (0x04) on top of the control opcode.
    localparam logic [7:0] c_dc_byte = c_op_disp | 8'h04
        | ((CURSOR_ON != 0) ? 8'h02 : 8'h00)
        | ((BLINK_ON  != 0) ? 8'h01 : 8'h00);

    lcd_state_e         r_state;
    logic               r_e;
    logic [9:0]         r_instruction;
    logic               r_instr_enable;
    logic               r_init_done;
    logic               r_busy;

    lcd_state_e         w_next;
    logic               w_advance;
    logic               w_load;
    logic [c_cnt_w-1:0] w_value;
    logic               w_expired;

    function automatic lcd_state_e f_next(input lcd_state_e s);
        lcd_state_e v;
        case (s)
            ST_W15:     v = ST_P3A;
            ST_P3A:     v = ST_W4_1;
            ST_W4_1:    v = ST_P3B;
            ST_P3B:     v = ST_W100;
            ST_W100:    v = ST_P3C;
            ST_P3C:     v = ST_W40A;
            ST_W40A:    v = (DATA_MODE != 0) ? ST_CFG_FS : ST_P2;
            ST_P2:      v = ST_W40B;
            ST_W40B:    v = ST_CFG_FS;
            ST_CFG_FS:  v = ST_CFG_EM;
            ST_CFG_EM:  v = ST_CFG_DC;
            ST_CFG_DC:  v = ST_CFG_CLR;
            ST_CFG_CLR: v = ST_W1_64;
            ST_W1_64:   v = ST_DONE;
            default:    v = ST_W15;
        endcase
        return v;
    endfunction

    function automatic logic f_is_pulse(input lcd_state_e s);
        return (s == ST_P3A) || (s == ST_P3B) || (s == ST_P3C) || (s == ST_P2);
    endfunction

    function automatic logic f_is_timed(input lcd_state_e s);
        return f_is_pulse(s) || (s == ST_W15) || (s == ST_W4_1) || (s == ST_W100)
            || (s == ST_W40A) || (s == ST_W40B) || (s == ST_W1_64);
    endfunction

    function automatic logic f_is_cfg(input lcd_state_e s);
        return (s == ST_CFG_FS) || (s == ST_CFG_EM) || (s == ST_CFG_DC) || (s == ST_CFG_CLR);
    endfunction

    // Counter preload is N-1 so that a state lasts exactly N cycles.
    function automatic logic [c_cnt_w-1:0] f_duration(input lcd_state_e s);
        logic [c_cnt_w-1:0] v;
        case (s)
            ST_W15:                     v = c_cnt_w'(c_t15 - 1);
            ST_P3A, ST_P3B, ST_P3C,
            ST_P2:                      v = c_cnt_w'(PULSE_CYCLES - 1);
            ST_W4_1:                    v = c_cnt_w'(c_t4_1 - 1);
            ST_W100:                    v = c_cnt_w'(c_t100 - 1);
            ST_W40A, ST_W40B:           v = c_cnt_w'(c_t40 - 1);
            ST_W1_64:                   v = c_cnt_w'(c_t1_64 - 1);
            default:                    v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [9:0] f_word(input lcd_state_e s);
        logic [9:0] v;
        case (s)
            ST_P3A, ST_P3B, ST_P3C: v = c_raw3;
            ST_P2:                  v = c_raw2;
            ST_CFG_FS:              v = {2'b00, c_fs_byte};
            ST_CFG_EM:              v = {2'b00, c_em_byte};
            ST_CFG_DC:              v = {2'b00, c_dc_byte};
            ST_CFG_CLR:             v = {2'b00, c_op_clr};
            default:                v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        w_next = f_next(r_state);
        if (f_is_timed(r_state)) begin
            w_advance = w_expired;
        end else if (f_is_cfg(r_state)) begin
            w_advance = r_instr_enable && instr_done;
        end else if (r_state == ST_DONE) begin
            w_advance = restart;
        end else begin
            w_advance = 1'b1;
        end
        w_load  = w_advance && f_is_timed(w_next);
        w_value = f_duration(w_next);
    end

    lcd_wait_timer #(
        .WIDTH       (c_cnt_w),
        .RESET_VALUE (c_cnt_w'(c_t15 - 1))
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .value   (w_value),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_W15;
            r_e            <= 1'b0;
            r_instruction  <= '0;
            r_instr_enable <= 1'b0;
            r_init_done    <= 1'b0;
            r_busy         <= 1'b1;
        end else if (w_advance) begin
            r_state        <= w_next;
            r_e            <= f_is_pulse(w_next);
            r_instruction  <= f_word(w_next);
            r_instr_enable <= 1'b0;
            r_init_done    <= (w_next == ST_DONE);
            r_busy         <= (w_next != ST_DONE);
        end else if (f_is_cfg(r_state)) begin
            // Enable rises one cycle after entry, giving the gap between commands.
            r_instr_enable <= 1'b1;
        end
    end

    assign e            = r_e;
    assign instruction  = r_instruction;
    assign instr_enable = r_instr_enable;
    assign init_done    = r_init_done;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/lcd_init_ctrl.md
# lcd_init_ctrl

Parametrised HD44780-style LCD power-on initialisation and configuration controller. After reset it times the power-on waits, emits the raw wake-up pulses directly on `e`/`instruction`, then issues the configuration commands through the downstream instruction FSM via an enable/done handshake. It raises `init_done` when the display is ready. Unlike the fixed 4-bit/50 MHz controller, all delays derive from `CLK_HZ`, 4-bit or 8-bit bus mode is selectable, configuration bits are parameters, and a re-initialisation request is supported.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; all delays derive from it.
- `DATA_MODE`, 0: 0 = 4-bit bus, 1 = 8-bit bus.
- `TWO_LINE`, 1: function-set N bit.
- `FONT_5X10`, 0: function-set F bit.
- `ENTRY_INC`, 1: entry-mode I/D bit.
- `ENTRY_SHIFT`, 0: entry-mode S bit.
- `CURSOR_ON`, 0: display-control C bit.
- `BLINK_ON`, 0: display-control B bit.
- `PULSE_CYCLES`, 12: width of each raw `e` pulse (≥1).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `restart`  in  1  request re-initialisation; sampled only in DONE.
- `instr_done`  in  1  instruction FSM finished the current command.
- `instr_enable`  out  1  command request to the instruction FSM.
- `instruction`  out  10  {RS, RW, D7..D0}; RS = RW = 0 always.
- `e`  out  1  raw enable pulse during wake-up only.
- `init_done`  out  1  high while in DONE.
- `busy`  out  1  high in every state except DONE.

## Operation
- Cycle constants: T15 = CLK_HZ/1000·15, T4_1 = CLK_HZ/10000·41, T100 = CLK_HZ/10000, T40 = CLK_HZ/100000·4, T1_64 = CLK_HZ/100000·164.
- Raw nibble/byte: RAW3 = 0x003 (4-bit) or 0x030 (8-bit). RAW2 = 0x002.
- Function-set word: 0x20 | DATA_MODE<<4 | TWO_LINE<<3 | FONT_5X10<<2.
- Entry-mode word: 0x04 | ENTRY_INC<<1 | ENTRY_SHIFT.
- Display-on word: 0x0C | CURSOR_ON<<1 | BLINK_ON.
- Clear word: 0x01.
- State sequence: W15 → P3A → W4_1 → P3B → W100 → P3C → W40A → [P2 → W40B, 4-bit only] → CFG_FS → CFG_EM → CFG_DC → CFG_CLR → W1_64 → DONE. 8-bit mode goes from W40A directly to CFG_FS.
- Wait states W*: `e` = 0, `instruction` = 0, `instr_enable` = 0.
- Pulse states P*: `e` = 1, `instruction` = RAW3 or RAW2.
- CFG states: `e` = 0, `instruction` = command word, `instr_enable` = 1 until `instr_done` is sampled high.
  - On that edge: `instr_enable` → 0, advance to the next state.
  - Next command's enable rises one cycle later, so there is exactly a 1-cycle low gap between commands.
- A single shared down-counter times every W*/P* state: load N−1 on entry, leave when it reaches 0, so each state lasts exactly N cycles. Counter width = clog2(T15).
- DONE: `init_done` = 1, `busy` = 0. `restart` = 1 → W15 with `init_done` = 0 on the next edge.
- `restart` in any other state is ignored (never abandons a handshake).
- `instr_done` outside CFG states is ignored.

## Timing
- Reset (async assert): state W15, counter = T15−1. Outputs: `e` = 0, `instruction` = 0, `instr_enable` = 0, `init_done` = 0, `busy` = 1.
- All outputs are registered; no combinational input→output paths.
- First `e` rise occurs exactly T15 cycles after the first rising edge following reset release.
- Consecutive `e` pulses are separated by exactly T4_1, T100, T40 low cycles.
- `instruction` is stable for the whole time `instr_enable` is high.
- `init_done` rises exactly T1_64 cycles after the edge that sampled the CLR `instr_done`.
- Reset mid-handshake: outputs drop immediately; the sequence restarts from W15.

## Structure
- Shared package `lcd_pkg`:
  - state encoding;
  - opcode base constants (CLR 0x01, ENTRY 0x04, DISP 0x08, FSET 0x20, RAW3, RAW2);
  - constant function `us_to_cycles(clk_hz, tenth_us)`.
- One natural sub-module, `lcd_wait_timer`:
  - inputs `load`, `value`; output `expired`;
  - the parametrised down-counter, reusable by the write-data FSM.

## Test plan
- Default 4-bit, CLK_HZ = 1_000_000, responder pulses `instr_done` 5 cycles after enable → `e` pulses at cycle 15000, 15012+4100, … with `instruction` 0x003, 0x003, 0x003, 0x002, each exactly 12 cycles, gaps 4100/100/40/40.
- Same run, configuration phase → commands 0x028, 0x006, 0x00C, 0x001 in order; enable low exactly 1 cycle between commands; `init_done` = 1 exactly 1640 cycles after the last done.
- DATA_MODE = 1 → three pulses of 0x030, no 0x002 pulse, function set 0x038.
- TWO_LINE = 0, ENTRY_SHIFT = 1, CURSOR_ON = 1, BLINK_ON = 1 → commands 0x020, 0x007, 0x00F, 0x001.
- `restart` pulse in DONE → `init_done` = 0 and `busy` = 1 next cycle, full sequence repeats. `restart` held during W4_1 → no effect on timing.
- `reset` = 0 asserted while CFG_EM has enable high → `instr_enable`, `e`, `instruction`, `init_done` go to 0 without a clock edge; after release the first `e` rise is again at T15.
